fc_mac_2: RTL and testbench
===========================

// Module: fc_mac_2
// PURPOSE
//  Sequential fully-connected layer; consumes the 2x5x5 signed map from the 2-channel 2x2 max-pool stage.
//  Flattens the map to 50 values and computes NOUT fixed-point dot products with one shared MAC.
//  Start/done handshake; result array feeds the classifier/argmax stage.
// PARAMETERS
//  bitwidth  16  data, weight, bias and output width (signed two's complement)
//  NOUT      10  number of output neurons
//  FRAC       8  fractional bits of the Q format shared by data, weights, bias, outputs
//  ACCW      40  accumulator width; must be >= 2*bitwidth+6 and >= bitwidth+FRAC+1
// PORTS
//  clk                    in   1                     rising-edge clock
//  rst                    in   1                     synchronous, active-high reset
//  start                  in   1                     request a run; sampled only in IDLE
//  featuremap_maxpooled   in   [1:0][4:0][4:0] x bw  signed pooled map, captured on accepted start
//  weights                in   [NOUT-1:0][49:0] x bw signed weights, flattened index k
//  bias                   in   [NOUT-1:0] x bw       signed bias per neuron
//  busy                   out  1                     high from cycle after accepted start through done cycle
//  done                   out  1                     one-cycle pulse, all fc_out valid
//  fc_out                 out  [NOUT-1:0] x bw       signed saturated results, held until overwritten
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, all fc_out=0, k=0, o=0, acc=0. Reset overrides every other event.
//  Flatten order: k = c*25 + i*5 + j for featuremap_maxpooled[c][i][j]; k in 0..49.
//  Capture: on accepted start, all 50 map values are registered into x[k].
//  weights and bias are NOT captured; they must be stable from start until done.
//  States and transitions:
//   IDLE : start=1 -> capture x; o=0; k=0; acc=sext(bias[0])<<<FRAC; -> MAC. Otherwise stay.
//   MAC  : acc += x[k]*weights[o][k] (full-precision signed product, sign-extended to ACCW).
//          k<49 -> k++. k==49 -> STORE.
//   STORE: fc_out[o] = sat(acc>>>FRAC), arithmetic shift, clamp to [-2^(bw-1), 2^(bw-1)-1].
//          o<NOUT-1 -> o++; k=0; acc=sext(bias[o+1])<<<FRAC; -> MAC. o==NOUT-1 -> DONE.
//   DONE : done=1 for exactly this cycle; -> IDLE.
//  Latency: start sampled at edge T; MAC, STORE and DONE occupy NOUT*51+1 cycles.
//   The done cycle is T+NOUT*51+1, so for NOUT=10 done is high 511 cycles after the start edge.
//  busy=1 in MAC, STORE and DONE; busy=0 in IDLE. done is registered, not combinational.
//  start while busy: ignored, no restart, no queueing. start in the same cycle as done (DONE state): ignored.
//  Back-to-back: start in the first IDLE cycle after done is accepted.
//  fc_out[o] changes only in STORE for neuron o; untouched entries keep the previous run's values.
//  Reset mid-run: abort, and all fc_out return to 0. No done is emitted for the aborted run.
//  No intermediate overflow: ACCW covers 50 full products plus the shifted bias; saturation only at STORE.
// TESTING
//  1 Zero map, bias[o]=3, random weights -> every fc_out=3; done exactly at start+511; busy high 510 cycles.
//  2 x[0][0][0]=256 (1.0), weights[o][0]=512 (2.0), other weights 0, bias 0 -> all fc_out=512.
//  3 Flatten order: only map[1][4][4]=256; weights[o][49]=256*(o+1), others 0 -> fc_out[o]=256*(o+1); k=0..48 weights ignored.
//  4 Saturation: all map and weights 0x7FFF -> fc_out=32767; map 0x7FFF with weights 0x8000 -> fc_out=-32768.
//  5 start pulsed at cycles +5 and +300 during a run -> single done at +511; results match golden model.
//  6 rst at cycle +100 -> busy=0, fc_out all 0, no done; restart with test 2 data -> correct outputs at +511.

Source files
------------

// File: rtl/fc_mac_2.sv
// Sequential fully-connected layer: 50 flattened pooled inputs, NOUT neurons,
// one shared signed MAC, start/done handshake, saturated fixed-point results.
module fc_mac_2 #(
  parameter int unsigned bitwidth = 16,
  parameter int unsigned NOUT     = 10,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned ACCW     = 40
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [1:0][4:0][4:0][bitwidth-1:0]   featuremap_maxpooled,
  input  logic [NOUT-1:0][49:0][bitwidth-1:0]  weights,
  input  logic [NOUT-1:0][bitwidth-1:0]        bias,
  output logic                                 busy,
  output logic                                 done,
  output logic [NOUT-1:0][bitwidth-1:0]        fc_out
);

  localparam int unsigned NX = 50;
  localparam int unsigned KW = $clog2(NX);
  localparam int unsigned OW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int unsigned PW = 2 * bitwidth;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                         state_q;
  logic [KW-1:0]                  k_q;
  logic [OW-1:0]                  o_q;
  logic signed [ACCW-1:0]         acc_q;
  logic signed [ACCW-1:0]         acc_d;
  logic                           busy_q;
  logic                           done_q;
  logic [NOUT-1:0][bitwidth-1:0]  fc_q;
  logic signed [bitwidth-1:0]     x_q [NX];

  logic signed [bitwidth-1:0]     x_cur;
  logic signed [bitwidth-1:0]     w_cur;
  logic signed [PW-1:0]           prod;
  logic signed [ACCW-1:0]         sh;
  logic [bitwidth-1:0]            sat_val;
  logic                           accept;

  // Accumulator preload: bias aligned to the product's 2*FRAC binary point.
  function automatic logic signed [ACCW-1:0] bias_acc(input logic [bitwidth-1:0] b);
    logic signed [ACCW-1:0] t;
    t = ACCW'($signed(b));
    return t <<< FRAC;
  endfunction

  assign accept = (state_q == IDLE) && start;

  // Shared MAC datapath and output saturation.
  always_comb begin
    x_cur = x_q[k_q];
    w_cur = $signed(weights[o_q][k_q]);
    prod  = x_cur * w_cur;
    acc_d = acc_q + ACCW'(prod);
    sh    = acc_q >>> FRAC;
    if (sh > SAT_MAX) begin
      sat_val = SAT_MAX[bitwidth-1:0];
    end else if (sh < SAT_MIN) begin
      sat_val = SAT_MIN[bitwidth-1:0];
    end else begin
      sat_val = sh[bitwidth-1:0];
    end
  end

  // Input map capture, flattened as k = c*25 + i*5 + j.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 5; j++) begin
            x_q[c*25 + i*5 + j] <= $signed(featuremap_maxpooled[c][i][j]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            k_q     <= '0;
            o_q     <= '0;
            acc_q   <= bias_acc(bias[0]);
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (k_q == KW'(NX - 1)) begin
            state_q <= STORE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        STORE: begin
          fc_q[o_q] <= sat_val;
          if (o_q == OW'(NOUT - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            o_q     <= o_q + OW'(1);
            k_q     <= '0;
            acc_q   <= bias_acc(bias[o_q + OW'(1)]);
            state_q <= MAC;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign fc_out = fc_q;

endmodule

// File: tb/tb_fc_mac_2.sv
// Directed bench for fc_mac_2: latency, flatten order, bias, saturation,
// ignored starts, mid-run reset and back-to-back runs.
module tb_fc_mac_2;

  localparam int unsigned BW   = 16;
  localparam int unsigned NO   = 10;
  localparam int unsigned LAT  = 511;

  logic                          clk;
  logic                          rst;
  logic                          start;
  logic [1:0][4:0][4:0][BW-1:0]  fmap;
  logic [NO-1:0][49:0][BW-1:0]   wts;
  logic [NO-1:0][BW-1:0]         bias_v;
  logic                          busy;
  logic                          done;
  logic [NO-1:0][BW-1:0]         fc_out;

  int n_vec;
  int n_err;

  fc_mac_2 #(.bitwidth(16), .NOUT(10), .FRAC(8), .ACCW(40)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .featuremap_maxpooled (fmap),
    .weights              (wts),
    .bias                 (bias_v),
    .busy                 (busy),
    .done                 (done),
    .fc_out               (fc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference dot product with floor shift and clamp, in 64-bit integers.
  function automatic logic [15:0] golden(input int o);
    longint acc;
    longint sh;
    acc = longint'($signed(bias_v[o])) * 256;
    for (int k = 0; k < 50; k++) begin
      acc += longint'($signed(fmap[k/25][(k%25)/5][k%5])) * longint'($signed(wts[o][k]));
    end
    sh = acc >>> 8;
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
    return 16'(sh);
  endfunction

  // Issues a start, then runs ncyc cycles (cycle 1 = first cycle after the start edge).
  task automatic run(input int ncyc, input int pa, input int pb, input int ra,
                     output int first_done, output int last_done,
                     output int busy_cnt, output int done_cnt);
    first_done = -1;
    last_done  = -1;
    busy_cnt   = 0;
    done_cnt   = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
        last_done = n;
      end else if (busy) begin
        busy_cnt++;
      end
      start = (n == pa) || (n == pb);
      rst   = (n == ra);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic load_unit();
    fmap = '0; wts = '0; bias_v = '0;
    fmap[0][0][0] = 16'd256;
    for (int o = 0; o < 10; o++) wts[o][0] = 16'd512;
  endtask

  task automatic test_reset();
    fmap = '1; wts = '1; bias_v = '1;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b expected 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %b expected 0", done); end
    n_vec++;
    if (fc_out !== '0) begin n_err++; $display("FAIL reset fc_out got %h expected 0", fc_out); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got %b expected 0", busy); end
  endtask

  task automatic test_bias_only();
    int fd, ld, bc, dc;
    fmap = '0;
    for (int o = 0; o < 10; o++) begin
      bias_v[o] = 16'd3;
      for (int k = 0; k < 50; k++) wts[o][k] = 16'($urandom);
    end
    run(600, 0, 0, 0, fd, ld, bc, dc);
    n_vec++;
    if (fd !== LAT) begin n_err++; $display("FAIL bias_latency got %0d expected %0d", fd, LAT); end
    n_vec++;
    if (dc !== 1) begin n_err++; $display("FAIL bias_done_count got %0d expected 1", dc); end
    n_vec++;
    if (bc !== 510) begin n_err++; $display("FAIL bias_busy_cycles got %0d expected 510", bc); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL bias_busy_after got %b expected 0", busy); end
    for (int o = 0; o < 10; o++) begin
      n_vec++;
      if (fc_out[o] !== 16'd3) begin
        n_err++; $display("FAIL bias fc_out[%0d] got %0d expected 3", o, $signed(fc_out[o]));
      end
    end
  endtask

  task automatic test_unit();
    int fd, ld, bc, dc;
    load_unit();
    run(600, 0, 0, 0, fd, ld, bc, dc);
    n_vec++;
    if (fd !== LAT) begin n_err++; $display("FAIL unit_latency got %0d expected %0d", fd, LAT); end
    for (int o = 0; o < 10; o++) begin
      n_vec++;
      if (fc_out[o] !== 16'd512) begin
        n_err++; $display("FAIL unit fc_out[%0d] got %0d expected 512", o, $signed(fc_out[o]));
      end
    end
  endtask

  task automatic test_flatten();
    int fd, ld, bc, dc;
    logic [15:0] exp;
    fmap = '0; bias_v = '0;
    fmap[1][4][4] = 16'd256;
    for (int o = 0; o < 10; o++) begin
      for (int k = 0; k < 49; k++) wts[o][k] = 16'($urandom);
      wts[o][49] = 16'(256 * (o + 1));
    end
    run(600, 0, 0, 0, fd, ld, bc, dc);
    n_vec++;
    if (dc !== 1) begin n_err++; $display("FAIL flatten_done_count got %0d expected 1", dc); end
    for (int o = 0; o < 10; o++) begin
      exp = 16'(256 * (o + 1));
      n_vec++;
      if (fc_out[o] !== exp) begin
        n_err++; $display("FAIL flatten fc_out[%0d] got %0d expected %0d", o, $signed(fc_out[o]), exp);
      end
    end
  endtask

  task automatic test_saturation();
    int fd, ld, bc, dc;
    fmap = '0; bias_v = '0;
    for (int k = 0; k < 50; k++) fmap[k/25][(k%25)/5][k%5] = 16'h7FFF;
    for (int o = 0; o < 10; o++) for (int k = 0; k < 50; k++) wts[o][k] = 16'h7FFF;
    run(600, 0, 0, 0, fd, ld, bc, dc);
    for (int o = 0; o < 10; o++) begin
      n_vec++;
      if (fc_out[o] !== 16'h7FFF) begin
        n_err++; $display("FAIL sat_pos fc_out[%0d] got %0d expected 32767", o, $signed(fc_out[o]));
      end
    end
    for (int o = 0; o < 10; o++) for (int k = 0; k < 50; k++) wts[o][k] = 16'h8000;
    run(600, 0, 0, 0, fd, ld, bc, dc);
    for (int o = 0; o < 10; o++) begin
      n_vec++;
      if (fc_out[o] !== 16'h8000) begin
        n_err++; $display("FAIL sat_neg fc_out[%0d] got %0d expected -32768", o, $signed(fc_out[o]));
      end
    end
  endtask

  task automatic test_start_ignored();
    int fd, ld, bc, dc;
    logic [15:0] exp;
    for (int k = 0; k < 50; k++) fmap[k/25][(k%25)/5][k%5] = 16'($urandom_range(0, 2047) - 1024);
    for (int o = 0; o < 10; o++) begin
      bias_v[o] = 16'($urandom_range(0, 4095) - 2048);
      for (int k = 0; k < 50; k++) wts[o][k] = 16'($urandom);
    end
    run(600, 5, 300, 0, fd, ld, bc, dc);
    n_vec++;
    if (fd !== LAT) begin n_err++; $display("FAIL ignore_latency got %0d expected %0d", fd, LAT); end
    n_vec++;
    if (dc !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d expected 1", dc); end
    for (int o = 0; o < 10; o++) begin
      exp = golden(o);
      n_vec++;
      if (fc_out[o] !== exp) begin
        n_err++; $display("FAIL ignore fc_out[%0d] got %0d expected %0d", o, $signed(fc_out[o]), $signed(exp));
      end
    end
  endtask

  task automatic test_reset_midrun();
    int fd, ld, bc, dc;
    run(600, 0, 0, 100, fd, ld, bc, dc);
    n_vec++;
    if (dc !== 0) begin n_err++; $display("FAIL abort_done_count got %0d expected 0", dc); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b expected 0", busy); end
    n_vec++;
    if (fc_out !== '0) begin n_err++; $display("FAIL abort_fc_out got %h expected 0", fc_out); end
    load_unit();
    run(600, 0, 0, 0, fd, ld, bc, dc);
    n_vec++;
    if (fd !== LAT) begin n_err++; $display("FAIL restart_latency got %0d expected %0d", fd, LAT); end
    for (int o = 0; o < 10; o++) begin
      n_vec++;
      if (fc_out[o] !== 16'd512) begin
        n_err++; $display("FAIL restart fc_out[%0d] got %0d expected 512", o, $signed(fc_out[o]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd, ld, bc, dc;
    logic [15:0] exp;
    fmap = '0; wts = '0; bias_v = '0;
    fmap[0][2][3] = 16'd512;
    for (int o = 0; o < 10; o++) begin
      wts[o][13] = 16'(128 * o);
      bias_v[o]  = 16'(o);
    end
    // start held in the done cycle (ignored) and the following IDLE cycle (accepted)
    run(1100, 511, 512, 0, fd, ld, bc, dc);
    n_vec++;
    if (fd !== LAT) begin n_err++; $display("FAIL b2b_first_done got %0d expected %0d", fd, LAT); end
    n_vec++;
    if (ld !== 1023) begin n_err++; $display("FAIL b2b_second_done got %0d expected 1023", ld); end
    n_vec++;
    if (dc !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d expected 2", dc); end
    n_vec++;
    if (bc !== 1020) begin n_err++; $display("FAIL b2b_busy_cycles got %0d expected 1020", bc); end
    for (int o = 0; o < 10; o++) begin
      exp = 16'(256 * o + o);
      n_vec++;
      if (fc_out[o] !== exp) begin
        n_err++; $display("FAIL b2b fc_out[%0d] got %0d expected %0d", o, $signed(fc_out[o]), exp);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0;
    fmap = '0; wts = '0; bias_v = '0;
    test_reset();
    test_bias_only();
    test_unit();
    test_flatten();
    test_saturation();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
